// File: rtl/dpram_defs.sv
// Shared definitions for the byte-enable dual-port RAM: clear FSM encodings,
// lane-count derivation and the string values used by the mode parameters.
package dpram_defs;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } clr_state_e;

  localparam string DPRAM_TRUE  = "TRUE";
  localparam string DPRAM_FALSE = "FALSE";

  function automatic int num_bytes(input int data_width, input int byte_width);
    return data_width / byte_width;
  endfunction

endpackage

// File: rtl/dpram_clear_seq.sv
// Post-reset clear sequencer: walks every address once, requesting an
// all-zero full-word write per cycle, and reports busy until done.
module dpram_clear_seq
  import dpram_defs::*;
#(
  parameter int ADDR_WIDTH = 9
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  busy,
  output logic                  clr_we,
  output logic [ADDR_WIDTH-1:0] clr_addr
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

  clr_state_e            state_q;
  logic [ADDR_WIDTH-1:0] addr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_CLEAR;
      addr_q  <= '0;
    end else begin
      case (state_q)
        ST_CLEAR: begin
          addr_q <= addr_q + 1'b1;
          if (addr_q == LAST_ADDR) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // No clearing write on a reset edge; the walk starts on the first edge after rst falls.
  assign busy     = (state_q == ST_CLEAR);
  assign clr_we   = busy && !rst;
  assign clr_addr = addr_q;

endmodule

// File: rtl/dpram_be.sv
// Simple dual-port RAM with per-byte write enables, write-first collision
// forwarding, a 1- or 2-stage read pipeline and optional clear-after-reset.
module dpram_be
  import dpram_defs::*;
#(
  parameter int    DATA_WIDTH     = 32,
  parameter int    BYTE_WIDTH     = 8,
  parameter int    ADDR_WIDTH     = 9,
  parameter string OUTPUT_REG     = "TRUE",
  parameter string RAM_INIT_FILE  = "",
  parameter string CLEAR_ON_RESET = "FALSE",
  localparam int   NUM_BYTES      = num_bytes(DATA_WIDTH, BYTE_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic                  we,
  input  logic [NUM_BYTES-1:0]  wbe,
  input  logic [ADDR_WIDTH-1:0] raddr,
  input  logic                  re,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rvalid,
  output logic                  busy
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  if (NUM_BYTES * BYTE_WIDTH != DATA_WIDTH) begin : g_bad_width
    $error("dpram_be: DATA_WIDTH must be a multiple of BYTE_WIDTH");
  end
  if (OUTPUT_REG != DPRAM_TRUE && OUTPUT_REG != DPRAM_FALSE) begin : g_bad_oreg
    $error("dpram_be: OUTPUT_REG must be TRUE or FALSE");
  end

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic                  busy_w;
  logic                  clr_we;
  logic [ADDR_WIDTH-1:0] clr_addr;

  if (CLEAR_ON_RESET == DPRAM_TRUE) begin : g_clear
    dpram_clear_seq #(
      .ADDR_WIDTH (ADDR_WIDTH)
    ) u_clear_seq (
      .clk      (clk),
      .rst      (rst),
      .busy     (busy_w),
      .clr_we   (clr_we),
      .clr_addr (clr_addr)
    );
  end else begin : g_no_clear
    assign busy_w   = 1'b0;
    assign clr_we   = 1'b0;
    assign clr_addr = '0;
  end

  assign busy = busy_w;

  logic                  wr_acc;
  logic                  rd_acc;
  logic                  wr_en;
  logic [NUM_BYTES-1:0]  wr_be;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;

  assign wr_acc = we && !busy_w;
  assign rd_acc = re && !busy_w;

  // The clearer only writes while busy, so it never competes with a user write.
  always_comb begin
    wr_en   = clr_we || wr_acc;
    wr_be   = clr_we ? '1 : wbe;
    wr_addr = clr_we ? clr_addr : waddr;
    wr_data = clr_we ? '0 : wdata;
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < NUM_BYTES; b++) begin
        if (wr_be[b]) mem_q[wr_addr][b*BYTE_WIDTH +: BYTE_WIDTH] <= wr_data[b*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end
  end

  logic [DATA_WIDTH-1:0] rd_word_d;

  always_comb begin
    rd_word_d = mem_q[raddr];
    for (int b = 0; b < NUM_BYTES; b++) begin
      if (wr_acc && wbe[b] && (waddr == raddr)) begin
        rd_word_d[b*BYTE_WIDTH +: BYTE_WIDTH] = wdata[b*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end
  end

  logic [DATA_WIDTH-1:0] stage1_q;
  logic                  v1_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stage1_q <= '0;
      v1_q     <= 1'b0;
    end else begin
      v1_q <= rd_acc;
      if (rd_acc) stage1_q <= rd_word_d;
    end
  end

  if (OUTPUT_REG == DPRAM_TRUE) begin : g_oreg
    logic [DATA_WIDTH-1:0] stage2_q;
    logic                  v2_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        stage2_q <= '0;
        v2_q     <= 1'b0;
      end else begin
        stage2_q <= stage1_q;
        v2_q     <= v1_q;
      end
    end

    assign rdata  = stage2_q;
    assign rvalid = v2_q;
  end else begin : g_no_oreg
    assign rdata  = stage1_q;
    assign rvalid = v1_q;
  end

endmodule

// File: tb/tb_dpram_be.sv
// Bench for dpram_be: two instances (registered output without clear, and
// unregistered output with clear) driven in lockstep against a word-array model.
module tb_dpram_be;

  localparam int AW    = 4;
  localparam int DW    = 32;
  localparam int NB    = 4;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b0;
  logic          we = 1'b0;
  logic          re = 1'b0;
  logic [NB-1:0] wbe = '0;
  logic [AW-1:0] waddr = '0;
  logic [AW-1:0] raddr = '0;
  logic [DW-1:0] wdata = '0;

  logic [DW-1:0] rdata_a, rdata_b;
  logic          rvalid_a, rvalid_b, busy_a, busy_b;

  dpram_be #(
    .DATA_WIDTH (DW), .BYTE_WIDTH (8), .ADDR_WIDTH (AW),
    .OUTPUT_REG ("TRUE"), .RAM_INIT_FILE (""), .CLEAR_ON_RESET ("FALSE")
  ) u_dut_a (
    .clk (clk), .rst (rst), .wdata (wdata), .waddr (waddr), .we (we), .wbe (wbe),
    .raddr (raddr), .re (re), .rdata (rdata_a), .rvalid (rvalid_a), .busy (busy_a)
  );

  dpram_be #(
    .DATA_WIDTH (DW), .BYTE_WIDTH (8), .ADDR_WIDTH (AW),
    .OUTPUT_REG ("FALSE"), .RAM_INIT_FILE (""), .CLEAR_ON_RESET ("TRUE")
  ) u_dut_b (
    .clk (clk), .rst (rst), .wdata (wdata), .waddr (waddr), .we (we), .wbe (wbe),
    .raddr (raddr), .re (re), .rdata (rdata_b), .rvalid (rvalid_b), .busy (busy_b)
  );

  // Reference model: memory image per instance, queue of issued reads {valid,data}.
  logic [DW-1:0] mm [2][DEPTH];
  logic [DW:0]   exp_q0[$];
  logic [DW:0]   exp_q1[$];
  logic [DW-1:0] last_d [2];
  int            clr_left = 0;
  int            n_checks = 0;
  int            n_pass = 0;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Reads surface after lat edges; rdata keeps the most recent delivered word.
  task automatic pipe(input int k, input logic v, input logic [DW-1:0] d,
                      output logic ov, output logic [DW-1:0] od);
    logic [DW:0] f;
    int          n;
    int          lat;
    lat = (k == 0) ? 2 : 1;
    if (k == 0) begin
      exp_q0.push_back({v, d});
      if (exp_q0.size() > lat) void'(exp_q0.pop_front());
      n = exp_q0.size();
      f = exp_q0[0];
    end else begin
      exp_q1.push_back({v, d});
      if (exp_q1.size() > lat) void'(exp_q1.pop_front());
      n = exp_q1.size();
      f = exp_q1[0];
    end
    ov = (n == lat) && f[DW];
    if (ov) last_d[k] = f[DW-1:0];
    od = last_d[k];
  endtask

  task automatic tick(input logic r, input logic w, input logic [NB-1:0] be, input logic [AW-1:0] wa,
                      input logic [DW-1:0] wd, input logic rr, input logic [AW-1:0] ra);
    logic          ev [2];
    logic [DW-1:0] ed [2];
    logic          eb [2];
    logic          busy_now, acc_w, acc_r;
    rst = r; we = w; wbe = be; waddr = wa; wdata = wd; re = rr; raddr = ra;
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (r) begin
        if (k == 0) exp_q0.delete();
        else exp_q1.delete();
        last_d[k] = '0;
        ev[k] = 1'b0;
        ed[k] = '0;
        eb[k] = (k == 1);
        if (k == 1) clr_left = DEPTH;
      end else begin
        busy_now = (k == 1) && (clr_left > 0);
        acc_w = w && !busy_now;
        acc_r = rr && !busy_now;
        for (int b = 0; b < NB; b++) begin
          if (acc_w && be[b]) mm[k][wa][b*8 +: 8] = wd[b*8 +: 8];
        end
        if (busy_now) begin
          mm[k][DEPTH - clr_left] = '0;
          clr_left--;
        end
        // Write-first: the read sees the array after this edge's write.
        pipe(k, acc_r, mm[k][ra], ev[k], ed[k]);
        eb[k] = (k == 1) && (clr_left > 0);
      end
    end
    #1;
    check("a_rvalid", DW'(rvalid_a), DW'(ev[0]));
    check("a_rdata", rdata_a, ed[0]);
    check("a_busy", DW'(busy_a), DW'(eb[0]));
    check("b_rvalid", DW'(rvalid_b), DW'(ev[1]));
    check("b_rdata", rdata_b, ed[1]);
    check("b_busy", DW'(busy_b), DW'(eb[1]));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, '0, '0, '0, 1'b0, '0);
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [NB-1:0] be, input logic [DW-1:0] d);
    tick(1'b0, 1'b1, be, a, d, 1'b0, '0);
  endtask

  task automatic rd(input logic [AW-1:0] a);
    tick(1'b0, 1'b0, '0, '0, '0, 1'b1, a);
  endtask

  task automatic pulse_rst();
    tick(1'b1, 1'b0, '0, '0, '0, 1'b0, '0);
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      last_d[k] = '0;
      for (int a = 0; a < DEPTH; a++) mm[k][a] = '0;
    end

    pulse_rst();
    pulse_rst();
    idle(DEPTH);

    for (int a = 0; a < DEPTH; a++) wr(AW'(a), 4'hF, $urandom() | 32'h1);

    wr(4'd5, 4'hF, 32'hDEADBEEF);
    rd(4'd5);
    idle(2);
    wr(4'd5, 4'b0101, 32'h11223344);
    rd(4'd5);
    idle(2);

    wr(4'd7, 4'hF, 32'hAAAAAAAA);
    tick(1'b0, 1'b1, 4'b0011, 4'd7, 32'h00001234, 1'b1, 4'd7);
    idle(2);

    for (int a = 0; a < 8; a++) rd(AW'(a));
    idle(3);

    // Read in flight when reset lands, then the clear walk with an ignored write.
    rd(4'd3);
    pulse_rst();
    for (int i = 0; i < DEPTH; i++) begin
      if (i == 4) wr(4'd2, 4'hF, 32'h5A5A5A5A);
      else idle(1);
    end
    for (int a = 0; a < DEPTH; a++) rd(AW'(a));
    idle(2);

    pulse_rst();
    idle(9);
    pulse_rst();
    idle(DEPTH);
    rd(4'd0);
    idle(2);

    for (int i = 0; i < 400; i++) begin
      logic          r, w, rr;
      logic [AW-1:0] wa, ra;
      r  = ($urandom_range(0, 63) == 0);
      w  = !r && ($urandom_range(0, 1) == 1);
      rr = ($urandom_range(0, 2) != 0);
      wa = AW'($urandom_range(0, DEPTH - 1));
      ra = ($urandom_range(0, 3) == 0) ? wa : AW'($urandom_range(0, DEPTH - 1));
      tick(r, w, NB'($urandom_range(0, 15)), wa, $urandom(), rr, ra);
    end
    idle(3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
